// File: rtl/lib_timer_multi.sv
// Time-of-day timer: prescaled minute tick, hour/minute counters with a
// programmable day length, and NUM_CH edge-triggered alarm channels.
module lib_timer_multi #(
  parameter int TICK_DIV      = 6,
  parameter int HOURS_PER_DAY = 24,
  parameter int MINS_PER_HOUR = 60,
  parameter int NUM_CH        = 4,
  parameter int CH_W          = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              run_en,
  input  logic              set_en,
  input  logic [4:0]        set_hour,
  input  logic [5:0]        set_min,
  output logic              set_err,
  input  logic              ch_wr,
  input  logic [CH_W-1:0]   ch_sel,
  input  logic              ch_en,
  input  logic [4:0]        ch_hour,
  input  logic [5:0]        ch_min,
  output logic [NUM_CH-1:0] alarm_pulse,
  output logic              alarm_any,
  output logic              min_tick,
  output logic              day_wrap,
  output logic [4:0]        hour,
  output logic [5:0]        min,
  output logic [10:0]       time_out
);

  localparam int PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] LAST_P = PW'(TICK_DIV - 1);
  localparam logic [4:0]    LAST_H = 5'(HOURS_PER_DAY - 1);
  localparam logic [5:0]    LAST_M = 6'(MINS_PER_HOUR - 1);

  logic [PW-1:0] presc_q, presc_d;
  logic [4:0]    hour_q, hour_d;
  logic [5:0]    min_q, min_d;
  logic          min_tick_q, min_tick_d;
  logic          day_wrap_q, day_wrap_d;
  logic          changed_q, changed_d;
  logic          set_err_q, set_err_d;

  logic          ch_en_q   [NUM_CH];
  logic          ch_en_d   [NUM_CH];
  logic [4:0]    ch_hour_q [NUM_CH];
  logic [4:0]    ch_hour_d [NUM_CH];
  logic [5:0]    ch_min_q  [NUM_CH];
  logic [5:0]    ch_min_d  [NUM_CH];

  logic [NUM_CH-1:0] alarm_q, alarm_d;

  logic tick;
  logic load_ok;

  assign tick    = run_en && (presc_q == LAST_P);
  assign load_ok = set_en && (set_hour <= LAST_H) && (set_min <= LAST_M);

  // Prescaler and time counters; a valid load overrides and discards a coincident tick.
  always_comb begin
    presc_d    = presc_q;
    hour_d     = hour_q;
    min_d      = min_q;
    min_tick_d = 1'b0;
    day_wrap_d = 1'b0;
    changed_d  = 1'b0;
    set_err_d  = set_en && !load_ok;
    if (load_ok) begin
      hour_d    = set_hour;
      min_d     = set_min;
      presc_d   = '0;
      changed_d = 1'b1;
    end else if (tick) begin
      presc_d    = '0;
      changed_d  = 1'b1;
      min_tick_d = 1'b1;
      if (min_q == LAST_M) begin
        min_d = '0;
        if (hour_q == LAST_H) begin
          hour_d     = '0;
          day_wrap_d = 1'b1;
        end else begin
          hour_d = hour_q + 5'd1;
        end
      end else begin
        min_d = min_q + 6'd1;
      end
    end else if (run_en) begin
      presc_d = presc_q + PW'(1);
    end
  end

  // Channel config next-state; out-of-range ch_sel matches no channel.
  // Alarms compare against the config as it stands after this cycle's write,
  // so disabling a channel in its match cycle suppresses the pulse.
  always_comb begin
    alarm_d = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      ch_en_d[k]   = ch_en_q[k];
      ch_hour_d[k] = ch_hour_q[k];
      ch_min_d[k]  = ch_min_q[k];
      if (ch_wr && (ch_sel == CH_W'(k))) begin
        ch_en_d[k]   = ch_en;
        ch_hour_d[k] = ch_hour;
        ch_min_d[k]  = ch_min;
      end
      alarm_d[k] = changed_q && ch_en_d[k] &&
                   (hour_q == ch_hour_d[k]) && (min_q == ch_min_d[k]);
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      presc_q    <= '0;
      hour_q     <= '0;
      min_q      <= '0;
      min_tick_q <= 1'b0;
      day_wrap_q <= 1'b0;
      changed_q  <= 1'b0;
      set_err_q  <= 1'b0;
      alarm_q    <= '0;
      for (int k = 0; k < NUM_CH; k++) begin
        ch_en_q[k]   <= 1'b0;
        ch_hour_q[k] <= '0;
        ch_min_q[k]  <= '0;
      end
    end else begin
      presc_q    <= presc_d;
      hour_q     <= hour_d;
      min_q      <= min_d;
      min_tick_q <= min_tick_d;
      day_wrap_q <= day_wrap_d;
      changed_q  <= changed_d;
      set_err_q  <= set_err_d;
      alarm_q    <= alarm_d;
      for (int k = 0; k < NUM_CH; k++) begin
        ch_en_q[k]   <= ch_en_d[k];
        ch_hour_q[k] <= ch_hour_d[k];
        ch_min_q[k]  <= ch_min_d[k];
      end
    end
  end

  assign set_err     = set_err_q;
  assign alarm_pulse = alarm_q;
  assign alarm_any   = |alarm_q;
  assign min_tick    = min_tick_q;
  assign day_wrap    = day_wrap_q;
  assign hour        = hour_q;
  assign min         = min_q;
  assign time_out    = {hour_q, min_q};

endmodule

// File: tb/tb_lib_timer_multi.sv
// Directed bench for lib_timer_multi with default parameters.
module tb_lib_timer_multi;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        run_en = 1'b0;
  logic        set_en = 1'b0;
  logic [4:0]  set_hour = '0;
  logic [5:0]  set_min = '0;
  logic        set_err;
  logic        ch_wr = 1'b0;
  logic [1:0]  ch_sel = '0;
  logic        ch_en = 1'b0;
  logic [4:0]  ch_hour = '0;
  logic [5:0]  ch_min = '0;
  logic [3:0]  alarm_pulse;
  logic        alarm_any;
  logic        min_tick;
  logic        day_wrap;
  logic [4:0]  hour;
  logic [5:0]  min;
  logic [10:0] time_out;

  int n_cmp = 0;
  int n_bad = 0;

  lib_timer_multi dut (
    .clk(clk), .rst(rst), .run_en(run_en), .set_en(set_en),
    .set_hour(set_hour), .set_min(set_min), .set_err(set_err),
    .ch_wr(ch_wr), .ch_sel(ch_sel), .ch_en(ch_en), .ch_hour(ch_hour),
    .ch_min(ch_min), .alarm_pulse(alarm_pulse), .alarm_any(alarm_any),
    .min_tick(min_tick), .day_wrap(day_wrap), .hour(hour), .min(min),
    .time_out(time_out)
  );

  always #5 clk = ~clk;

  // Outputs are sampled 1 time unit after the rising edge; inputs change there too.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    n_cmp++;
    if ({hour, min, time_out, min_tick, day_wrap, set_err, alarm_pulse, alarm_any} !== '0) begin
      n_bad++;
      $display("FAIL reset_state: got time=%0d:%0d tick=%b wrap=%b err=%b alarm=%b any=%b, want all 0",
               hour, min, min_tick, day_wrap, set_err, alarm_pulse, alarm_any);
    end
    rst = 1'b0;
  endtask

  task automatic test_tick_rate();
    int ticks = 0;
    int wraps = 0;
    run_en = 1'b1;
    for (int i = 1; i <= 360; i++) begin
      step();
      if (min_tick) ticks++;
      if (day_wrap) wraps++;
      if (i <= 12) begin
        n_cmp++;
        if (min_tick !== (i % 6 == 0)) begin
          n_bad++;
          $display("FAIL tick_cadence cycle %0d: got min_tick=%b, want %b", i, min_tick, (i % 6 == 0));
        end
      end
    end
    n_cmp++;
    if (ticks != 60 || wraps != 0) begin
      n_bad++;
      $display("FAIL tick_count: got ticks=%0d wraps=%0d, want 60 and 0", ticks, wraps);
    end
    n_cmp++;
    if (time_out !== 11'b00001_000000 || hour !== 5'd1 || min !== 6'd0) begin
      n_bad++;
      $display("FAIL hour_carry: got time_out=%b, want 00001000000", time_out);
    end
  endtask

  task automatic test_day_wrap();
    set_en = 1'b1; set_hour = 5'd23; set_min = 6'd59;
    step();
    set_en = 1'b0;
    n_cmp++;
    if (hour !== 5'd23 || min !== 6'd59 || min_tick !== 1'b0) begin
      n_bad++;
      $display("FAIL load_2359: got %0d:%0d tick=%b, want 23:59 tick=0", hour, min, min_tick);
    end
    for (int i = 1; i <= 7; i++) begin
      step();
      n_cmp++;
      if (min_tick !== (i == 6) || day_wrap !== (i == 6)) begin
        n_bad++;
        $display("FAIL wrap_pulse cycle %0d: got tick=%b wrap=%b, want %b", i, min_tick, day_wrap, (i == 6));
      end
      if (i == 6) begin
        n_cmp++;
        if (time_out !== 11'd0) begin
          n_bad++;
          $display("FAIL wrap_time: got time_out=%0d, want 0", time_out);
        end
      end
    end
  endtask

  task automatic test_alarm_edge();
    ch_wr = 1'b1; ch_sel = 2'd2; ch_en = 1'b1; ch_hour = 5'd7; ch_min = 6'd30;
    step();
    ch_wr = 1'b0;
    set_en = 1'b1; set_hour = 5'd7; set_min = 6'd29;
    step();
    set_en = 1'b0;
    for (int i = 1; i <= 12; i++) begin
      step();
      if (i == 6) begin
        run_en = 1'b0;
        n_cmp++;
        if (hour !== 5'd7 || min !== 6'd30) begin
          n_bad++;
          $display("FAIL alarm_time: got %0d:%0d, want 7:30", hour, min);
        end
      end
      n_cmp++;
      if (alarm_pulse !== ((i == 7) ? 4'b0100 : 4'b0000) || alarm_any !== (i == 7)) begin
        n_bad++;
        $display("FAIL alarm_ch2 cycle %0d: got pulse=%b any=%b, want %b", i, alarm_pulse, alarm_any,
                 (i == 7) ? 4'b0100 : 4'b0000);
      end
    end
  endtask

  task automatic test_load_vs_tick();
    run_en = 1'b1;
    set_en = 1'b1; set_hour = 5'd8; set_min = 6'd0;
    step();
    set_en = 1'b0;
    repeat (5) step();
    set_en = 1'b1; set_hour = 5'd24; set_min = 6'd0;
    step();
    set_en = 1'b0;
    n_cmp++;
    if (hour !== 5'd8 || min !== 6'd1 || min_tick !== 1'b1 || set_err !== 1'b1) begin
      n_bad++;
      $display("FAIL bad_hour_tick: got %0d:%0d tick=%b err=%b, want 8:1 tick=1 err=1",
               hour, min, min_tick, set_err);
    end
    step();
    n_cmp++;
    if (set_err !== 1'b0) begin
      n_bad++;
      $display("FAIL set_err_width: got err=%b, want 0", set_err);
    end
    run_en = 1'b0;
    set_en = 1'b1; set_hour = 5'd3; set_min = 6'd60;
    step();
    set_en = 1'b0;
    n_cmp++;
    if (hour !== 5'd8 || min !== 6'd1 || set_err !== 1'b1) begin
      n_bad++;
      $display("FAIL bad_min: got %0d:%0d err=%b, want 8:1 err=1", hour, min, set_err);
    end
    run_en = 1'b1;
    set_en = 1'b1; set_hour = 5'd10; set_min = 6'd10;
    step();
    set_en = 1'b0;
    repeat (5) step();
    set_en = 1'b1; set_hour = 5'd10; set_min = 6'd20;
    step();
    set_en = 1'b0;
    n_cmp++;
    if (hour !== 5'd10 || min !== 6'd20 || min_tick !== 1'b0 || set_err !== 1'b0) begin
      n_bad++;
      $display("FAIL load_over_tick: got %0d:%0d tick=%b err=%b, want 10:20 tick=0 err=0",
               hour, min, min_tick, set_err);
    end
    for (int i = 1; i <= 6; i++) begin
      step();
      n_cmp++;
      if (min_tick !== (i == 6)) begin
        n_bad++;
        $display("FAIL presc_cleared cycle %0d: got tick=%b, want %b", i, min_tick, (i == 6));
      end
    end
    n_cmp++;
    if (min !== 6'd21) begin
      n_bad++;
      $display("FAIL after_load_tick: got min=%0d, want 21", min);
    end
  endtask

  task automatic test_disable_race();
    run_en = 1'b0;
    ch_wr = 1'b1; ch_sel = 2'd0; ch_en = 1'b1; ch_hour = 5'd12; ch_min = 6'd0;
    step();
    ch_sel = 2'd3;
    step();
    ch_wr = 1'b0;
    run_en = 1'b1;
    set_en = 1'b1; set_hour = 5'd11; set_min = 6'd59;
    step();
    set_en = 1'b0;
    repeat (5) step();
    ch_wr = 1'b1; ch_sel = 2'd3; ch_en = 1'b0; ch_hour = 5'd12; ch_min = 6'd0;
    step();
    ch_wr = 1'b0;
    run_en = 1'b0;
    n_cmp++;
    if (hour !== 5'd12 || min !== 6'd0) begin
      n_bad++;
      $display("FAIL noon_time: got %0d:%0d, want 12:0", hour, min);
    end
    step();
    n_cmp++;
    if (alarm_pulse !== 4'b0001 || alarm_any !== 1'b1) begin
      n_bad++;
      $display("FAIL disable_race: got pulse=%b any=%b, want 0001 1", alarm_pulse, alarm_any);
    end
    ch_wr = 1'b1; ch_sel = 2'd1; ch_en = 1'b1; ch_hour = 5'd12; ch_min = 6'd0;
    step();
    ch_wr = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      n_cmp++;
      if (alarm_pulse !== 4'b0000) begin
        n_bad++;
        $display("FAIL program_current cycle %0d: got pulse=%b, want 0000", i, alarm_pulse);
      end
    end
    set_en = 1'b1; set_hour = 5'd12; set_min = 6'd0;
    step();
    set_en = 1'b0;
    step();
    n_cmp++;
    if (alarm_pulse !== 4'b0011 || alarm_any !== 1'b1) begin
      n_bad++;
      $display("FAIL reload_same: got pulse=%b any=%b, want 0011 1", alarm_pulse, alarm_any);
    end
    step();
    n_cmp++;
    if (alarm_pulse !== 4'b0000) begin
      n_bad++;
      $display("FAIL reload_once: got pulse=%b, want 0000", alarm_pulse);
    end
  endtask

  task automatic test_mid_reset();
    run_en = 1'b1;
    set_en = 1'b1; set_hour = 5'd7; set_min = 6'd29;
    step();
    set_en = 1'b0;
    repeat (6) step();
    n_cmp++;
    if (hour !== 5'd7 || min !== 6'd30 || alarm_pulse !== 4'b0000) begin
      n_bad++;
      $display("FAIL pending_setup: got %0d:%0d pulse=%b, want 7:30 0000", hour, min, alarm_pulse);
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    n_cmp++;
    if ({time_out, min_tick, day_wrap, set_err, alarm_pulse, alarm_any} !== '0) begin
      n_bad++;
      $display("FAIL mid_reset: got time_out=%0d tick=%b wrap=%b err=%b pulse=%b any=%b, want all 0",
               time_out, min_tick, day_wrap, set_err, alarm_pulse, alarm_any);
    end
    step();
    n_cmp++;
    if (alarm_pulse !== 4'b0000 || alarm_any !== 1'b0) begin
      n_bad++;
      $display("FAIL no_escape: got pulse=%b any=%b, want 0000 0", alarm_pulse, alarm_any);
    end
    repeat (2) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int i = 1; i <= 6; i++) begin
      step();
      n_cmp++;
      if (min_tick !== (i == 6)) begin
        n_bad++;
        $display("FAIL presc_reset cycle %0d: got tick=%b, want %b", i, min_tick, (i == 6));
      end
    end
    run_en = 1'b0;
    set_en = 1'b1; set_hour = 5'd7; set_min = 6'd30;
    step();
    set_en = 1'b0;
    step();
    n_cmp++;
    if (alarm_pulse !== 4'b0000) begin
      n_bad++;
      $display("FAIL channels_cleared: got pulse=%b, want 0000", alarm_pulse);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_tick_rate();
    test_day_wrap();
    test_alarm_edge();
    test_load_vs_tick();
    test_disable_race();
    test_mid_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
